pwm_rc_dac: RTL and testbench
=============================

// Module: pwm_rc_dac
// PURPOSE
// - Digital PWM generator driving a first-order RC low-pass (one R cell, one C cell) to form a DAC.
// - Sits directly upstream of the passive R/C footprint cells: its PWM pin is the R.A net.
// - R.B and C.A form the filtered node aout_o; C.B ties to gnd_io.
// - Duty words arrive over a valid/ready handshake. New duty applies only at period boundaries (glitch-free).
// PARAMETERS
// - WIDTH      8       counter width; period = 2**WIDTH clk cycles
// - R_VALUE    "10k"   value string passed to the R cell
// - C_VALUE    "100n"  value string passed to the C cell
// - LAYER      "F.Cu"  layer passed to both passive cells
// - R_REF      "R1"    reference designator of the R cell
// - C_REF      "C1"    reference designator of the C cell
// PORTS
// - clk            in     1        system clock, rising edge
// - rst            in     1        asynchronous reset, active-high
// - en_i           in     1        1 = run counter; 0 = hold counter and force pwm_o low
// - duty_i         in     WIDTH+1  requested high-cycles per period, 0..2**WIDTH; larger values saturate
// - duty_valid_i   in     1        duty_i valid
// - duty_ready_o   out    1        shadow register empty, transfer accepted
// - period_o       out    1        one-cycle pulse on the cycle cnt wraps to 0
// - pwm_o          out    1        registered PWM output, also drives R.A
// - aout_o         inout  1        filtered analog node (R.B / C.A)
// - gnd_io         inout  1        ground net (C.B)
// BEHAVIOUR
// - Reset (async, immediate):
//   - cnt=0, duty_act=0, shadow empty, duty_ready_o=1, period_o=0, pwm_o=0.
// - Handshake:
//   - Transfer occurs when duty_valid_i && duty_ready_o at a clk edge. duty_ready_o = !shadow_full.
//   - Shadow stores min(duty_i, 2**WIDTH) and sets shadow_full.
//   - duty_i must hold while valid && !ready. There is no combinational path from valid to ready.
// - Counter:
//   - When en_i=1: cnt <= cnt+1, wrapping 2**WIDTH-1 -> 0. When en_i=0: cnt holds.
// - Boundary load:
//   - On the edge where cnt goes 2**WIDTH-1 -> 0 with en_i=1: if shadow_full, duty_act <= shadow and shadow_full <= 0.
//   - period_o=1 for the cycle after that edge, i.e. the cycle cnt==0.
// - Simultaneous wrap-load and new transfer:
//   - Ready was 0 (shadow full), so no transfer can coincide.
//   - The cycle after the load shows ready=1.
// - Output:
//   - pwm_o <= en_i && (cnt_next < duty_act_next), registered.
//   - pwm_o is high for exactly duty_act cycles of each period, starting the cycle cnt==0.
//   - duty 0 = constant low. duty 2**WIDTH = constant high (100%).
// - en_i falling mid-period:
//   - pwm_o low on the next edge; cnt frozen.
//   - On re-enable, resumes from the frozen cnt with the same duty_act. No boundary is skipped or repeated.
// - Reset asserted mid-period: everything returns to reset values at once, and any pending shadow is discarded.
// - Analog:
//   - aout_o ~= VDD*duty_act/2**WIDTH, time constant R*C.
//   - The block only instantiates the cells; it does not model analog behaviour.
// STRUCTURE
// - Shared package pcb_dac_pkg:
//   - DUTY_W = WIDTH+1 helper function.
//   - Default R/C value strings.
//   - Default LAYER constant.
// - Sub-module pwm_core:
//   - Contains counter, shadow/active duty registers, handshake, compare.
//   - Purely synchronous plus async reset.
// - Top level:
//   - pwm_core.
//   - R cell #(.value(R_VALUE),.layer(LAYER),.reference(R_REF)) (pwm_o, aout_o).
//   - C cell #(.value(C_VALUE),.layer(LAYER),.reference(C_REF)) (aout_o, gnd_io).
// TESTING (WIDTH=4 unless noted)
// - Reset then en=1, no duty written -> pwm_o stays 0; period_o pulses every 16 cycles; ready=1 throughout.
// - Write duty=5 at cnt=3 -> ready drops next cycle; after wrap, pwm_o high exactly 5 of 16 cycles; ready=1 on the cnt==0 cycle.
// - Write duty=16 and duty=31 in separate periods -> pwm_o constant 1 both periods (31 saturates to 16).
// - Hold valid with a second word while shadow full -> no transfer until the boundary; second word applies one period later, first word never lost.
// - en_i=0 at cnt=7 for 10 cycles, duty=8 -> pwm_o 0 while disabled; on re-enable cnt resumes at 7 and period_o fires after 9 more cycles.
// - Assert rst at cnt=9 with shadow full -> all outputs reset immediately; shadow discarded; next period pwm_o=0.

Source files
------------

// File: rtl/pcb_dac_pkg.sv
// Shared constants and helpers for the PWM + RC DAC slice.
package pcb_dac_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam     R_VALUE_DEF = "10k";
  localparam     C_VALUE_DEF = "100n";
  localparam     LAYER_DEF   = "F.Cu";

  // A duty word needs one more bit than the counter so that 100% is representable.
  function automatic int duty_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/c_cell.sv
// Passive capacitor footprint cell: connectivity and placement metadata only.
module c_cell #(
  parameter value     = "100n",
  parameter layer     = "F.Cu",
  parameter reference = "C1"
) (
  inout wire a,
  inout wire b
);

  // The cell is a footprint: metadata is carried as parameters, pins are only observed.
  localparam int unused_meta = $bits(value) + $bits(layer) + $bits(reference);

  logic unused_pins;
  assign unused_pins = a ^ b;

endmodule

// File: rtl/pwm_core.sv
// PWM core: free-running counter, shadow/active duty registers with a
// valid/ready handshake, and the registered compare that forms the PWM.
module pwm_core import pcb_dac_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [duty_w(WIDTH)-1:0]   duty_i,
  input  logic                       duty_valid_i,
  output logic                       duty_ready_o,
  output logic                       period_o,
  output logic                       pwm_o
);

  localparam int                DW       = duty_w(WIDTH);
  localparam logic [DW-1:0]     DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [DW-1:0]    duty_act;
  logic [DW-1:0]    duty_act_next;
  logic [DW-1:0]    shadow;
  logic [DW-1:0]    shadow_next;
  logic [DW-1:0]    duty_sat;
  logic             shadow_full;
  logic             shadow_full_next;
  logic             wrap;
  logic             xfer;
  logic             pwm_next;

  // Ready depends only on the shadow flop, never on valid.
  assign duty_ready_o = !shadow_full;

  // Next-state logic: counter advance, boundary load, handshake capture, compare.
  always_comb begin
    wrap             = en_i && (cnt == CNT_MAX);
    xfer             = duty_valid_i && !shadow_full;
    duty_sat         = (duty_i > DUTY_MAX) ? DUTY_MAX : duty_i;
    cnt_next         = cnt;
    duty_act_next    = duty_act;
    shadow_next      = shadow;
    shadow_full_next = shadow_full;

    if (en_i) begin
      cnt_next = cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_next = cnt;
    end

    // A full shadow blocks transfers, so load and capture never coincide.
    if (wrap && shadow_full) begin
      duty_act_next    = shadow;
      shadow_full_next = 1'b0;
    end else if (xfer) begin
      shadow_next      = duty_sat;
      shadow_full_next = 1'b1;
    end else begin
      shadow_full_next = shadow_full;
    end

    pwm_next = en_i && ({1'b0, cnt_next} < duty_act_next);
  end

  // State and registered outputs; async reset discards any pending shadow word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= {WIDTH{1'b0}};
      duty_act    <= {DW{1'b0}};
      shadow      <= {DW{1'b0}};
      shadow_full <= 1'b0;
      period_o    <= 1'b0;
      pwm_o       <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      duty_act    <= duty_act_next;
      shadow      <= shadow_next;
      shadow_full <= shadow_full_next;
      period_o    <= wrap;
      pwm_o       <= pwm_next;
    end
  end

endmodule

// File: rtl/r_cell.sv
// Passive resistor footprint cell: connectivity and placement metadata only.
module r_cell #(
  parameter value     = "10k",
  parameter layer     = "F.Cu",
  parameter reference = "R1"
) (
  inout wire a,
  inout wire b
);

  // The cell is a footprint: metadata is carried as parameters, pins are only observed.
  localparam int unused_meta = $bits(value) + $bits(layer) + $bits(reference);

  logic unused_pins;
  assign unused_pins = a ^ b;

endmodule

// File: rtl/pwm_rc_dac.sv
// PWM DAC top: PWM core driving a first-order RC filter built from footprint cells.
module pwm_rc_dac import pcb_dac_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter     R_VALUE = R_VALUE_DEF,
  parameter     C_VALUE = C_VALUE_DEF,
  parameter     LAYER   = LAYER_DEF,
  parameter     R_REF   = "R1",
  parameter     C_REF   = "C1"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [duty_w(WIDTH)-1:0] duty_i,
  input  logic                     duty_valid_i,
  output logic                     duty_ready_o,
  output logic                     period_o,
  output wire                      pwm_o,
  inout  wire                      aout_o,
  inout  wire                      gnd_io
);

  logic pwm_reg;

  pwm_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .duty_i       (duty_i),
    .duty_valid_i (duty_valid_i),
    .duty_ready_o (duty_ready_o),
    .period_o     (period_o),
    .pwm_o        (pwm_reg)
  );

  // The PWM flop output is the R.A net.
  assign pwm_o = pwm_reg;

  r_cell #(.value(R_VALUE), .layer(LAYER), .reference(R_REF)) u_r (
    .a (pwm_o),
    .b (aout_o)
  );

  c_cell #(.value(C_VALUE), .layer(LAYER), .reference(C_REF)) u_c (
    .a (aout_o),
    .b (gnd_io)
  );

endmodule

// File: tb/tb_pwm_rc_dac.sv
// Directed bench for pwm_rc_dac at WIDTH=4 (16-cycle period).
module tb_pwm_rc_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic [4:0] duty_i;
  logic       duty_valid_i;
  logic       duty_ready_o;
  logic       period_o;
  wire        pwm_o;
  wire        aout_o;
  wire        gnd_io;

  pwm_rc_dac #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .duty_i       (duty_i),
    .duty_valid_i (duty_valid_i),
    .duty_ready_o (duty_ready_o),
    .period_o     (period_o),
    .pwm_o        (pwm_o),
    .aout_o       (aout_o),
    .gnd_io       (gnd_io)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected-state bookkeeping; all duty values are supplied by hand.
  int exp_cnt      = 0;
  int exp_duty     = 0;
  int exp_pend     = 0;
  int exp_pend_val = 0;
  int exp_period   = 0;
  int xfer_req     = 0;
  int xfer_val     = 0;
  int high_cnt     = 0;
  int per_cnt      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  // One clock per iteration, then check pwm, period and ready against expectations.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic en_at_edge;
      int   pend_before;
      en_at_edge  = en_i;
      pend_before = exp_pend;
      exp_period  = 0;
      if (en_i) begin
        exp_cnt    = (exp_cnt + 1) % 16;
        exp_period = (exp_cnt == 0) ? 1 : 0;
      end
      @(posedge clk);
      #1;
      if (exp_period == 1 && pend_before == 1) begin
        exp_duty = exp_pend_val;
        exp_pend = 0;
      end
      if (xfer_req == 1 && pend_before == 0) begin
        exp_pend     = 1;
        exp_pend_val = xfer_val;
        xfer_req     = 0;
        duty_valid_i = 1'b0;
      end
      if (pwm_o === 1'b1) high_cnt++;
      if (period_o === 1'b1) per_cnt++;
      chk("pwm", {31'd0, pwm_o}, {31'd0, (en_at_edge && (exp_cnt < exp_duty))});
      chk("period", {31'd0, period_o}, exp_period);
      chk("ready", {31'd0, duty_ready_o}, (exp_pend == 0) ? 1 : 0);
    end
  endtask

  // Offer a duty word; sat is the hand-saturated value it should become.
  task automatic write(input int val, input int sat);
    duty_i       = val[4:0];
    duty_valid_i = 1'b1;
    xfer_req     = 1;
    xfer_val     = sat;
    run(1);
  endtask

  initial begin
    rst          = 1'b1;
    en_i         = 1'b0;
    duty_i       = 5'd0;
    duty_valid_i = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, duty_ready_o}, 32'd1);
    chk("rst_pwm", {31'd0, pwm_o}, 32'd0);
    chk("rst_period", {31'd0, period_o}, 32'd0);
    rst  = 1'b0;
    en_i = 1'b1;

    // No duty written: pwm low, period every 16 cycles, ready high
    per_cnt = 0;
    run(32);
    chk("idle_periods", per_cnt, 32'd2);

    // duty=5 written at cnt=3, applied after the wrap
    run(3);
    write(5, 5);
    run(11);
    high_cnt = 0;
    run(16);
    chk("duty5_highs", high_cnt, 32'd5);

    // duty=16 then duty=31 (saturates to 16): constant high
    write(16, 16);
    run(16);
    write(31, 16);
    run(15);
    high_cnt = 0;
    run(16);
    chk("duty16_highs", high_cnt, 32'd16);

    // Second word held while the shadow is full; both words applied in order
    write(3, 3);
    duty_i       = 5'd9;
    duty_valid_i = 1'b1;
    xfer_req     = 1;
    xfer_val     = 9;
    run(14);
    chk("hold_valid", {31'd0, duty_valid_i}, 32'd1);
    high_cnt = 0;
    run(16);
    chk("duty3_highs", high_cnt, 32'd3);
    high_cnt = 0;
    run(16);
    chk("duty9_highs", high_cnt, 32'd9);

    // duty=8, disable at cnt=7 for 10 cycles, then resume
    write(8, 8);
    run(16);
    run(7);
    en_i     = 1'b0;
    high_cnt = 0;
    run(10);
    chk("dis_highs", high_cnt, 32'd0);
    en_i    = 1'b1;
    per_cnt = 0;
    run(8);
    chk("resume_no_period", per_cnt, 32'd0);
    run(1);
    chk("resume_period", per_cnt, 32'd1);

    // Reset at cnt=9 with a pending shadow word
    write(12, 12);
    run(8);
    rst = 1'b1;
    #1;
    chk("mid_rst_pwm", {31'd0, pwm_o}, 32'd0);
    chk("mid_rst_period", {31'd0, period_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, duty_ready_o}, 32'd1);
    exp_cnt  = 0;
    exp_duty = 0;
    exp_pend = 0;
    #2;
    rst      = 1'b0;
    high_cnt = 0;
    run(32);
    chk("post_rst_highs", high_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
